// File: rtl/rename_map.sv
// rename_map: register alias table with a physical free list and a small
// circular stack of branch checkpoints (map snapshot + allocation mask).
module rename_map #(
    parameter int unsigned ARCH_REGS  = 32,
    parameter int unsigned PHYS_REGS  = 64,
    parameter int unsigned CKPT_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          ren_valid,
    input  logic                          ren_uses_rs,
    input  logic                          ren_uses_rt,
    input  logic                          ren_uses_rw,
    input  logic [$clog2(ARCH_REGS)-1:0]  ren_rs,
    input  logic [$clog2(ARCH_REGS)-1:0]  ren_rt,
    input  logic [$clog2(ARCH_REGS)-1:0]  ren_rw,
    input  logic                          ren_ckpt,
    output logic                          ren_ready,
    output logic [$clog2(PHYS_REGS)-1:0]  rs_phys,
    output logic [$clog2(PHYS_REGS)-1:0]  rt_phys,
    output logic [$clog2(PHYS_REGS)-1:0]  rw_phys,
    output logic [$clog2(PHYS_REGS)-1:0]  rw_old_phys,
    output logic [$clog2(CKPT_DEPTH)-1:0] ckpt_id,

    input  logic                          commit_valid,
    input  logic [$clog2(PHYS_REGS)-1:0]  commit_old_phys,

    input  logic                          resolve_valid,
    input  logic                          resolve_mispredict,
    input  logic [$clog2(CKPT_DEPTH)-1:0] resolve_id,

    output logic [$clog2(PHYS_REGS):0]    free_count,
    output logic [$clog2(CKPT_DEPTH):0]   ckpt_count
);

    localparam int unsigned AW = $clog2(ARCH_REGS);
    localparam int unsigned PW = $clog2(PHYS_REGS);
    localparam int unsigned CW = $clog2(CKPT_DEPTH);

    // Architectural state
    logic [PW-1:0]        map_q   [ARCH_REGS];
    logic [PHYS_REGS-1:0] free_q;
    logic [PW-1:0]        snap_q  [CKPT_DEPTH][ARCH_REGS];
    logic [PHYS_REGS-1:0] mask_q  [CKPT_DEPTH];
    logic [CW-1:0]        head_q;
    logic [CW-1:0]        tail_q;
    logic [PW:0]          free_count_q;
    logic [CW:0]          ckpt_count_q;

    // Next-state and decode
    logic [PHYS_REGS-1:0]  free_d;
    logic [PW:0]           free_count_d;
    logic [CW:0]           ckpt_count_d;
    logic [CW-1:0]         head_d;
    logic [CW-1:0]         tail_d;
    logic [CW-1:0]         restore_depth;
    logic [PW-1:0]         free_pick;
    logic [PHYS_REGS-1:0]  alloc_onehot;
    logic [CKPT_DEPTH-1:0] ckpt_live;
    logic                  mispredict;
    logic                  resolve_ok;
    logic                  need_phys;
    logic                  ckpt_full;
    logic                  do_ren;
    logic                  do_alloc;
    logic                  do_ckpt;

    assign mispredict = resolve_valid && resolve_mispredict;
    assign resolve_ok = resolve_valid && !resolve_mispredict;
    assign need_phys  = ren_uses_rw && (ren_rw != '0);
    assign ckpt_full  = (ckpt_count_q == (CW+1)'(CKPT_DEPTH));

    // A restore cycle owns the map, so renames are held off during it
    assign ren_ready = !(need_phys && (free_count_q == '0))
                    && !(ren_ckpt && ckpt_full)
                    && !mispredict;

    assign do_ren   = ren_valid && ren_ready;
    assign do_alloc = do_ren && need_phys;
    assign do_ckpt  = do_ren && ren_ckpt;

    // Lowest-index free physical register (0 when the list is empty)
    always_comb begin
        free_pick = '0;
        for (int i = int'(PHYS_REGS) - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                free_pick = PW'(i);
            end
        end
    end

    assign alloc_onehot = do_alloc ? (PHYS_REGS'(1) << free_pick) : '0;

    // Which checkpoint slots lie between head and tail
    always_comb begin
        ckpt_live = '0;
        for (int k = 0; k < int'(CKPT_DEPTH); k++) begin
            logic [CW-1:0] age;
            age          = CW'(k) - head_q;
            ckpt_live[k] = ({1'b0, age} < ckpt_count_q);
        end
    end

    // Free list next state: restore refill, allocation, then commit release
    always_comb begin
        free_d = free_q;
        if (mispredict) begin
            free_d = free_d | mask_q[resolve_id];
        end
        free_d = free_d & ~alloc_onehot;
        if (commit_valid && (commit_old_phys != '0)) begin
            free_d[commit_old_phys] = 1'b1;
        end
        free_d[0] = 1'b0;
    end

    // Population count of the next free list
    always_comb begin
        free_count_d = '0;
        for (int i = 0; i < int'(PHYS_REGS); i++) begin
            free_count_d = free_count_d + (PW+1)'(free_d[i]);
        end
    end

    assign restore_depth = resolve_id - head_q;

    // Checkpoint pointer and occupancy next state
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        ckpt_count_d = ckpt_count_q;
        if (mispredict) begin
            tail_d       = resolve_id;
            ckpt_count_d = {1'b0, restore_depth};
        end else begin
            if (do_ckpt) begin
                tail_d       = tail_q + CW'(1);
                ckpt_count_d = ckpt_count_d + (CW+1)'(1);
            end
            if (resolve_ok && (ckpt_count_q != '0)) begin
                head_d       = head_q + CW'(1);
                ckpt_count_d = ckpt_count_d - (CW+1)'(1);
            end
        end
    end

    // Free list, pointers and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PHYS_REGS); i++) begin
                free_q[i] <= (i >= int'(ARCH_REGS));
            end
            head_q       <= '0;
            tail_q       <= '0;
            free_count_q <= (PW+1)'(PHYS_REGS - ARCH_REGS);
            ckpt_count_q <= '0;
        end else begin
            free_q       <= free_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            free_count_q <= free_count_d;
            ckpt_count_q <= ckpt_count_d;
        end
    end

    // Map table: identity on reset, snapshot on restore, else new mapping
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) begin
                map_q[i] <= PW'(i);
            end
        end else if (mispredict) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) begin
                map_q[i] <= snap_q[resolve_id][i];
            end
        end else if (do_alloc) begin
            map_q[ren_rw] <= free_pick;
        end
    end

    // Snapshot captures the map before the branch's own rename
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(CKPT_DEPTH); k++) begin
                for (int i = 0; i < int'(ARCH_REGS); i++) begin
                    snap_q[k][i] <= '0;
                end
            end
        end else if (do_ckpt) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) begin
                snap_q[tail_q][i] <= map_q[i];
            end
        end
    end

    // Allocation masks: fresh slot starts with this rename, live slots accumulate
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(CKPT_DEPTH); k++) begin
                mask_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(CKPT_DEPTH); k++) begin
                if (do_ckpt && (CW'(k) == tail_q)) begin
                    mask_q[k] <= alloc_onehot;
                end else if (ckpt_live[k]) begin
                    mask_q[k] <= mask_q[k] | alloc_onehot;
                end
            end
        end
    end

    // Lookup and status outputs
    assign rs_phys     = ren_uses_rs ? map_q[ren_rs] : '0;
    assign rt_phys     = ren_uses_rt ? map_q[ren_rt] : '0;
    assign rw_old_phys = ren_uses_rw ? map_q[ren_rw] : '0;
    assign rw_phys     = need_phys ? free_pick : '0;
    assign ckpt_id     = tail_q;
    assign free_count  = free_count_q;
    assign ckpt_count  = ckpt_count_q;

endmodule

// File: doc/rename_map.md
RENAME_MAP -- requirements
Module: rename_map

Parameters
REQ-001 SHALL have parameter ARCH_REGS, default 32, number of architectural registers (power of 2).
REQ-002 SHALL have parameter PHYS_REGS, default 64, number of physical registers (power of 2, > ARCH_REGS).
REQ-003 SHALL have parameter CKPT_DEPTH, default 4, number of branch checkpoints (power of 2).
REQ-004 SHALL derive AW=log2(ARCH_REGS), PW=log2(PHYS_REGS), CW=log2(CKPT_DEPTH).

Interface
REQ-005 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-006 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have ports ren_valid in 1, ren_uses_rs in 1, ren_uses_rt in 1, ren_uses_rw in 1  rename request qualifiers.
REQ-008 SHALL have ports ren_rs, ren_rt, ren_rw  in  AW each  architectural source and destination addresses.
REQ-009 SHALL have ports ren_ckpt  in  1  request also takes a checkpoint (conditional branch).
REQ-010 SHALL have ports ren_ready out 1; rs_phys, rt_phys, rw_phys, rw_old_phys out PW each; ckpt_id out CW.
REQ-011 SHALL have ports commit_valid in 1, commit_old_phys in PW  release a physical register at retirement.
REQ-012 SHALL have ports resolve_valid in 1, resolve_mispredict in 1, resolve_id in CW  branch resolution.
REQ-013 SHALL have ports free_count out PW+1, ckpt_count out CW+1  occupancy status.

Function
REQ-014 SHALL hold map table map[ARCH_REGS] (PW bits), free vector free[PHYS_REGS], CKPT_DEPTH snapshots of map plus per-checkpoint alloc_mask[PHYS_REGS], circular head/tail pointers.
REQ-015 SHALL drive rs_phys/rt_phys/rw_old_phys combinationally = map[addr] when the matching uses_* is high, else 0.
REQ-016 SHALL select rw_phys = lowest-index set bit of free; 0 when ren_uses_rw low or ren_rw==0.
REQ-017 SHALL treat architectural 0 as never renamed: map[0]=0 always; physical 0 never set in free.
REQ-018 SHALL assert ren_ready unless (uses_rw && rw!=0 && free_count==0) or (ren_ckpt && ckpt_count==CKPT_DEPTH) or (resolve_valid && resolve_mispredict).
REQ-019 SHALL, on ren_valid && ren_ready at posedge, with rw!=0: clear free[rw_phys], set map[rw]=rw_phys, set alloc_mask[k][rw_phys] for every live checkpoint k.
REQ-020 SHALL, on accepted ren_ckpt, capture the map as it is BEFORE this instruction's rename into slot tail, clear alloc_mask[tail] then OR in this instruction's allocation, output ckpt_id=tail, advance tail.
REQ-021 SHALL, on commit_valid with commit_old_phys!=0, set free[commit_old_phys] at posedge; commit of 0 ignored.
REQ-022 SHALL, on resolve_valid && !resolve_mispredict, release oldest checkpoint (head+1); resolve_id must equal head.
REQ-023 SHALL, on resolve_valid && resolve_mispredict, restore map from snapshot resolve_id, set free |= alloc_mask[resolve_id], set tail=resolve_id (discard it and all younger).
REQ-024 SHALL apply a same-cycle commit free in addition to a restore; a register freed by commit is never re-cleared by restore.
REQ-025 SHALL ignore a rename in the cycle of a mispredict restore (ren_ready low).
REQ-026 SHALL update free_count and ckpt_count in the same posedge as the events that change them; pointers wrap modulo CKPT_DEPTH.

Reset
REQ-027 SHALL, while rst high at posedge: map[i]=i; free[i]=1 for i>=ARCH_REGS else 0; head=tail=0; ckpt_count=0; free_count=PHYS_REGS-ARCH_REGS; all masks cleared; rst overrides all other inputs, including mid-rename/restore.

Verification
REQ-028 SHALL cover: after reset, rename rw=5 -> rw_phys=32, rw_old_phys=5; next cycle rs=5 reads rs_phys=32, free_count=31.
REQ-029 SHALL cover: 32 renames to rw=1 with no commits -> free_count=0, 33rd request ren_ready=0; one commit of phys 1 -> next rename gets rw_phys=1.
REQ-030 SHALL cover: rename r3->32, branch with ren_ckpt (id 0), renames r3->33, r4->34, mispredict id 0 -> map[3]=32, map[4]=4, free_count=31, ckpt_count=0.
REQ-031 SHALL cover: 4 checkpoints taken -> 5th ren_ckpt ren_ready=0; correct resolve id 0 -> ren_ready=1 next cycle, ckpt_count=3.
REQ-032 SHALL cover: mispredict and commit_old_phys=7 in same cycle -> phys 7 free afterwards; rename with rw=0 -> rw_phys=0, free_count unchanged.
REQ-033 SHALL cover: rst asserted during a renaming cycle -> all state equals REQ-027 values the following cycle.
